regfile_sb: RTL

- Parametrised general-purpose register file for the pipelined datapath; successor to the single 64-bit enable register.
- Replaces per-register instances with DEPTH entries of WIDTH bits.
- Provides one byte-masked write port, two combinational read ports with optional write-to-read bypass, and an optional hardwired-zero entry 0.
- Includes a per-entry pending-write scoreboard: the issue stage marks a destination busy, writeback clears it. The hazard unit stalls on the busy flags.

---
 rtl/regfile_sb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a byte-masked write port, two
// combinational read ports (optional write-to-read bypass), an optional
// hardwired-zero entry 0 and a per-entry pending-write scoreboard whose
// population count is tracked incrementally in a registered counter.
module regfile_sb #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int SW      = WIDTH / 8,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [SW-1:0]    wstrb,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_addr,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             busy_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_b,
    output logic [CW-1:0]    pending_cnt
);

    localparam logic [31:0] DEPTH_U = DEPTH;

    // An index is usable when it lies inside the array and is not the
    // hardwired-zero entry.
    function automatic logic idx_valid(input logic [AW-1:0] idx);
        logic in_range;
        logic is_zero;
        in_range = ({{(32-AW){1'b0}}, idx} < DEPTH_U);
        is_zero  = (ZERO_REG != 0) && (idx == {AW{1'b0}});
        return in_range && !is_zero;
    endfunction

    // Replace the bytes selected by strb with the matching bytes of nw.
    function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old,
                                                    input logic [WIDTH-1:0] nw,
                                                    input logic [SW-1:0]    strb);
        logic [WIDTH-1:0] res;
        res = old;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = nw[8*i +: 8];
            end else begin
                res[8*i +: 8] = old[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             wr_ok_s;
    logic             iss_ok_s;
    logic             inc_s;
    logic             dec_s;
    logic [AW-1:0]    raddr_s [2];
    logic [WIDTH-1:0] rdata_s [2];
    logic             rbusy_s [2];

    assign wr_ok_s  = we && idx_valid(waddr);
    assign iss_ok_s = issue_valid && idx_valid(issue_addr);

    // Scoreboard next state: retire clears, issue sets, and a set on the same
    // entry wins because the new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        inc_s  = 1'b0;
        dec_s  = 1'b0;
        if (wr_ok_s) begin
            busy_d[waddr] = 1'b0;
            dec_s = busy_q[waddr] && !(iss_ok_s && (issue_addr == waddr));
        end else begin
            dec_s = 1'b0;
        end
        if (iss_ok_s) begin
            busy_d[issue_addr] = 1'b1;
            inc_s = !busy_q[issue_addr];
        end else begin
            inc_s = 1'b0;
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, inc_s} - {{(CW-1){1'b0}}, dec_s};
    end

    // Storage, busy flags and pending counter; reset drops any pending marks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            busy_q <= {DEPTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_q[waddr] <= byte_merge(mem_q[waddr], wdata, wstrb);
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign raddr_s[0] = raddr_a;
    assign raddr_s[1] = raddr_b;

    // Read ports: invalid index reads zero/not busy; a same-cycle write to the
    // addressed entry is forwarded when bypass is enabled.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_s[p] = {WIDTH{1'b0}};
            rbusy_s[p] = 1'b0;
            if (!idx_valid(raddr_s[p])) begin
                rdata_s[p] = {WIDTH{1'b0}};
                rbusy_s[p] = 1'b0;
            end else if ((BYPASS != 0) && we && (waddr == raddr_s[p])) begin
                rdata_s[p] = byte_merge(mem_q[raddr_s[p]], wdata, wstrb);
                rbusy_s[p] = iss_ok_s && (issue_addr == raddr_s[p]);
            end else begin
                rdata_s[p] = mem_q[raddr_s[p]];
                rbusy_s[p] = busy_q[raddr_s[p]];
            end
        end
    end

    assign rdata_a     = rdata_s[0];
    assign busy_a      = rbusy_s[0];
    assign rdata_b     = rdata_s[1];
    assign busy_b      = rbusy_s[1];
    assign pending_cnt = cnt_q;

endmodule
